// File: rtl/cv32e40s_fencei_sequencer.sv
// rtl/cv32e40s_fencei_sequencer.sv - fence.i retirement handshake sequencer beside the controller FSM
// Optional ack timeout enabled by defining FENCEI_ACK_TIMEOUT_EN.
module cv32e40s_fencei_sequencer #(
  parameter int ACK_TIMEOUT_CYCLES = 255,
  parameter int TIMEOUT_W          = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        fencei_wb_i,
  input  logic [31:0] fencei_pc_i,
  input  logic        lsu_busy_i,
  input  logic        fencei_flush_ack_i,
  output logic        fencei_flush_req_o,
  output logic        halt_wb_o,
  output logic        kill_if_o,
  output logic        pc_set_o,
  output logic [31:0] pc_next_o,
  output logic        busy_o,
  output logic        done_o,
  output logic        timeout_o
);

  typedef enum logic [1:0] {
    IDLE,
    WAIT_LSU,
    REQ,
    REDIRECT
  } state_e;

  state_e      state_q;
  state_e      state_d;
  logic [31:0] pc_q;
  logic        capture;
  logic        timeout_hit;

`ifdef FENCEI_ACK_TIMEOUT_EN
  logic [TIMEOUT_W-1:0] count_q;
  logic                 timeout_q;

  assign timeout_hit = (count_q == TIMEOUT_W'(ACK_TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q   <= '0;
      timeout_q <= 1'b0;
    end else begin
      // Clear on REQ entry so every handshake gets the full budget.
      if (state_d == REQ && state_q != REQ) begin
        count_q <= '0;
      end else if (state_q == REQ && !fencei_flush_ack_i) begin
        count_q <= count_q + 1'b1;
      end
      timeout_q <= (state_q == REQ) && !fencei_flush_ack_i && timeout_hit;
    end
  end

  assign timeout_o = (state_q == REDIRECT) && timeout_q;
`else
  wire unused_cfg = (ACK_TIMEOUT_CYCLES == TIMEOUT_W);

  assign timeout_hit = 1'b0;
  assign timeout_o   = 1'b0;
`endif

  always_comb begin
    state_d            = state_q;
    capture            = 1'b0;
    halt_wb_o          = 1'b0;
    fencei_flush_req_o = 1'b0;
    kill_if_o          = 1'b0;
    pc_set_o           = 1'b0;
    done_o             = 1'b0;
    busy_o             = 1'b1;
    case (state_q)
      IDLE: begin
        busy_o = 1'b0;
        if (fencei_wb_i) begin
          // Hold WB already in the capture cycle so the fence.i cannot slip out.
          capture   = 1'b1;
          halt_wb_o = 1'b1;
          state_d   = lsu_busy_i ? WAIT_LSU : REQ;
        end
      end
      WAIT_LSU: begin
        halt_wb_o = 1'b1;
        if (!lsu_busy_i) begin
          state_d = REQ;
        end
      end
      REQ: begin
        halt_wb_o          = 1'b1;
        fencei_flush_req_o = 1'b1;
        if (fencei_flush_ack_i || timeout_hit) begin
          state_d = REDIRECT;
        end
      end
      REDIRECT: begin
        pc_set_o  = 1'b1;
        kill_if_o = 1'b1;
        done_o    = 1'b1;
        state_d   = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      pc_q    <= '0;
    end else begin
      state_q <= state_d;
      if (capture) begin
        pc_q <= fencei_pc_i + 32'd4;
      end
    end
  end

  assign pc_next_o = pc_q;

endmodule
